// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_unit
//  Purpose  : Multi-cycle multiply / divide unit that owns the HI/LO register
//             pair for the execute stage. Signed/unsigned multiply, MADD/MSUB
//             against HI/LO, radix-2 restoring divide, MTHI/MTLO writes.
//  Ports    :
//    clk        in   rising-edge clock
//    rst        in   asynchronous active-low reset
//    start_i    in   accept op_i/a_i/b_i this cycle (only when idle)
//    op_i       in   operation code (see c_OP_* below, others = NOP)
//    a_i, b_i   in   operands rs / rt
//    annul_i    in   flush the in-flight operation, no HI/LO write
//    busy_o     out  long operation in flight
//    stall_o    out  pipeline hold request
//    done_o     out  one-cycle result-valid pulse
//    res_hi_o   out  result high half / remainder
//    res_lo_o   out  result low half / quotient
//    hi_o, lo_o out  architectural HI / LO registers
//  Revision : 1.0  initial release
// ============================================================================
module muldiv_unit #(
  parameter int               WIDTH      = 32,
  parameter int               MUL_LAT    = 2,
  parameter logic [WIDTH-1:0] DIV_ZERO_Q = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             annul_i,
  output logic             busy_o,
  output logic             stall_o,
  output logic             done_o,
  output logic [WIDTH-1:0] res_hi_o,
  output logic [WIDTH-1:0] res_lo_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam logic [3:0] c_OP_MULT  = 4'd1;
  localparam logic [3:0] c_OP_MULTU = 4'd2;
  localparam logic [3:0] c_OP_DIV   = 4'd3;
  localparam logic [3:0] c_OP_DIVU  = 4'd4;
  localparam logic [3:0] c_OP_MTHI  = 4'd5;
  localparam logic [3:0] c_OP_MTLO  = 4'd6;
  localparam logic [3:0] c_OP_MADD  = 4'd7;
  localparam logic [3:0] c_OP_MADDU = 4'd8;
  localparam logic [3:0] c_OP_MSUB  = 4'd9;
  localparam logic [3:0] c_OP_MSUBU = 4'd10;

  // Counter must hold both MUL_LAT-1 and WIDTH-1.
  localparam int              c_CNT_MAX = (WIDTH > MUL_LAT) ? WIDTH : MUL_LAT;
  localparam int              c_CW      = $clog2(c_CNT_MAX) + 1;
  localparam logic [c_CW-1:0] c_MUL_CNT = c_CW'(MUL_LAT - 1);
  localparam logic [c_CW-1:0] c_DIV_CNT = c_CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] c_MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_MUL      = 3'd1,
    S_DIV_PREP = 3'd2,
    S_DIV_ITER = 3'd3,
    S_DIV_FIX  = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [3:0]         r_op;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [2*WIDTH-1:0] r_acc;
  logic [c_CW-1:0]    r_cnt;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]   r_dvs;
  logic               r_neg_q;
  logic               r_neg_r;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   r_res_hi;
  logic [WIDTH-1:0]   r_res_lo;

  // --------------------------------------------------------------------------
  // Opcode decode of the incoming request
  // --------------------------------------------------------------------------
  logic w_in_mul;
  logic w_in_div;
  logic w_in_long;
  logic w_accept;

  assign w_in_mul  = (op_i == c_OP_MULT)  || (op_i == c_OP_MULTU) ||
                     (op_i == c_OP_MADD)  || (op_i == c_OP_MADDU) ||
                     (op_i == c_OP_MSUB)  || (op_i == c_OP_MSUBU);
  assign w_in_div  = (op_i == c_OP_DIV) || (op_i == c_OP_DIVU);
  assign w_in_long = w_in_mul || w_in_div;
  assign w_accept  = (r_state == S_IDLE) && start_i && !annul_i;

  // --------------------------------------------------------------------------
  // Multiply datapath: operands extended to 2*WIDTH so a single truncated
  // multiplier gives the correct signed or unsigned double-width product.
  // --------------------------------------------------------------------------
  logic               w_mul_signed;
  logic [2*WIDTH-1:0] w_ext_a;
  logic [2*WIDTH-1:0] w_ext_b;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_mul_res;

  assign w_mul_signed = (r_op == c_OP_MULT) || (r_op == c_OP_MADD) ||
                        (r_op == c_OP_MSUB);
  assign w_ext_a = {{WIDTH{w_mul_signed & r_a[WIDTH-1]}}, r_a};
  assign w_ext_b = {{WIDTH{w_mul_signed & r_b[WIDTH-1]}}, r_b};
  assign w_prod  = w_ext_a * w_ext_b;

  always_comb begin
    w_mul_res = w_prod;
    if ((r_op == c_OP_MADD) || (r_op == c_OP_MADDU)) begin
      w_mul_res = r_acc + w_prod;
    end else if ((r_op == c_OP_MSUB) || (r_op == c_OP_MSUBU)) begin
      w_mul_res = r_acc - w_prod;
    end
  end

  // --------------------------------------------------------------------------
  // Divide datapath: one restoring shift-subtract step per cycle. The dividend
  // is shifted out of r_quo MSB-first while quotient bits shift in at the LSB.
  // --------------------------------------------------------------------------
  logic             w_div_signed;
  logic [WIDTH:0]   w_rem_sh;
  logic             w_fits;
  logic [WIDTH:0]   w_rem_sub;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic             w_div_ovf;

  assign w_div_signed = (r_op == c_OP_DIV);
  assign w_rem_sh     = {r_rem, r_quo[WIDTH-1]};
  assign w_fits       = (w_rem_sh >= {1'b0, r_dvs});
  assign w_rem_sub    = w_rem_sh - {1'b0, r_dvs};
  assign w_abs_a      = (w_div_signed && r_a[WIDTH-1]) ? -r_a : r_a;
  assign w_abs_b      = (w_div_signed && r_b[WIDTH-1]) ? -r_b : r_b;
  // Most-negative / -1 does not fit in WIDTH bits; pin the result explicitly.
  assign w_div_ovf    = w_div_signed && (r_a == c_MOST_NEG) && (r_b == '1);

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next state and handshake outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    busy_o      = (r_state != S_IDLE) && (r_state != S_DONE);
    done_o      = (r_state == S_DONE) && !annul_i;
    stall_o     = busy_o || (start_i && w_in_long && (r_state == S_IDLE));

    if (annul_i && (r_state != S_IDLE)) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept && w_in_mul) begin
            w_state_nxt = S_MUL;
          end else if (w_accept && w_in_div) begin
            w_state_nxt = S_DIV_PREP;
          end
        end
        S_MUL:      if (r_cnt == '0) w_state_nxt = S_DONE;
        S_DIV_PREP: w_state_nxt = S_DIV_ITER;
        S_DIV_ITER: if (r_cnt == '0) w_state_nxt = S_DIV_FIX;
        S_DIV_FIX:  w_state_nxt = S_DONE;
        S_DONE:     w_state_nxt = S_IDLE;
        default:    w_state_nxt = S_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Datapath registers and HI/LO
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvs    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_res_hi <= '0;
      r_res_lo <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op  <= op_i;
            r_a   <= a_i;
            r_b   <= b_i;
            r_acc <= {r_hi, r_lo};
            r_cnt <= c_MUL_CNT;
            if (op_i == c_OP_MTHI) r_hi <= a_i;
            if (op_i == c_OP_MTLO) r_lo <= a_i;
          end
        end
        S_MUL: begin
          if (!annul_i) begin
            if (r_cnt == '0) begin
              {r_res_hi, r_res_lo} <= w_mul_res;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
        end
        S_DIV_PREP: begin
          r_quo   <= w_abs_a;
          r_dvs   <= w_abs_b;
          r_rem   <= '0;
          r_neg_q <= w_div_signed && (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
          r_neg_r <= w_div_signed && r_a[WIDTH-1];
          r_cnt   <= c_DIV_CNT;
        end
        S_DIV_ITER: begin
          r_rem <= w_fits ? w_rem_sub[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
          r_quo <= {r_quo[WIDTH-2:0], w_fits};
          if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
        end
        S_DIV_FIX: begin
          if (!annul_i) begin
            if (r_b == '0) begin
              r_res_lo <= DIV_ZERO_Q;
              r_res_hi <= r_a;
            end else if (w_div_ovf) begin
              r_res_lo <= c_MOST_NEG;
              r_res_hi <= '0;
            end else begin
              r_res_lo <= r_neg_q ? -r_quo : r_quo;
              r_res_hi <= r_neg_r ? -r_rem : r_rem;
            end
          end
        end
        S_DONE: begin
          if (!annul_i) begin
            r_hi <= r_res_hi;
            r_lo <= r_res_lo;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign res_hi_o = r_res_hi;
  assign res_lo_o = r_res_lo;
  assign hi_o     = r_hi;
  assign lo_o     = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_muldiv_unit
//  Purpose  : Self-checking bench for muldiv_unit: directed vector table,
//             randomized ops against a reference model, and hand-written
//             sequences for annul, held start and mid-operation reset.
//  Revision : 1.0  initial release
// ============================================================================
module tb_muldiv_unit;

  localparam int c_W       = 32;
  localparam int c_MUL_LAT = 2;
  localparam int c_DIV_LAT = c_W + 2;

  logic          clk;
  logic          rst;
  logic          start_i;
  logic [3:0]    op_i;
  logic [c_W-1:0] a_i;
  logic [c_W-1:0] b_i;
  logic          annul_i;
  logic          busy_o;
  logic          stall_o;
  logic          done_o;
  logic [c_W-1:0] res_hi_o;
  logic [c_W-1:0] res_lo_o;
  logic [c_W-1:0] hi_o;
  logic [c_W-1:0] lo_o;

  int n_vec;
  int n_err;
  logic [c_W-1:0] m_hi;
  logic [c_W-1:0] m_lo;

  muldiv_unit #(.WIDTH(c_W), .MUL_LAT(c_MUL_LAT)) dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_i),
    .op_i     (op_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .annul_i  (annul_i),
    .busy_o   (busy_o),
    .stall_o  (stall_o),
    .done_o   (done_o),
    .res_hi_o (res_hi_o),
    .res_lo_o (res_lo_o),
    .hi_o     (hi_o),
    .lo_o     (lo_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic [3:0]     op;
    logic [c_W-1:0] a;
    logic [c_W-1:0] b;
    logic [c_W-1:0] hi;
    logic [c_W-1:0] lo;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int exp_lat(input logic [3:0] op);
    case (op)
      4'd1, 4'd2, 4'd7, 4'd8, 4'd9, 4'd10: return c_MUL_LAT;
      4'd3, 4'd4:                          return c_DIV_LAT;
      default:                             return 0;
    endcase
  endfunction

  // Architectural result {HI,LO} after op, from plain arithmetic.
  function automatic logic [63:0] ref_model(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [63:0] acc);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic signed [63:0] sp;
    logic [63:0]        up;
    int                 ia;
    int                 ib;
    int                 q;
    int                 r;
    sa = $signed(a);
    sb = $signed(b);
    sp = sa * sb;
    up = {32'd0, a} * {32'd0, b};
    case (op)
      4'd1:  return sp;
      4'd2:  return up;
      4'd7:  return acc + sp;
      4'd8:  return acc + up;
      4'd9:  return acc - sp;
      4'd10: return acc - up;
      4'd3: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        ia = $signed(a);
        ib = $signed(b);
        q  = ia / ib;
        r  = ia % ib;
        return {r[31:0], q[31:0]};
      end
      4'd4: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      4'd5:  return {a, acc[31:0]};
      4'd6:  return {acc[63:32], a};
      default: return acc;
    endcase
  endfunction

  // Caller is positioned at a negedge; returns positioned at a negedge.
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el);
    int lat;
    int edges;
    bit seen;
    lat       = exp_lat(op);
    start_i   = 1'b1;
    op_i      = op;
    a_i       = a;
    b_i       = b;
    #1;
    chk("stall_at_request", 64'(stall_o), (lat != 0) ? 64'd1 : 64'd0);
    @(posedge clk);
    #1;
    start_i = 1'b0;
    op_i    = 4'd0;
    if (lat == 0) begin
      @(negedge clk);
      chk("short_op_no_done", 64'(done_o), 64'd0);
      chk("short_op_no_busy", 64'(busy_o), 64'd0);
      chk("short_op_hilo", {hi_o, lo_o}, {eh, el});
    end else begin
      edges = 0;
      seen  = 1'b0;
      while (!seen && edges < 100) begin
        @(posedge clk);
        edges++;
        @(negedge clk);
        if (done_o) seen = 1'b1;
        else if (edges == 1) chk("busy_after_accept", 64'(busy_o), 64'd1);
      end
      if (!seen) begin
        chk("done_timeout", 64'd0, 64'd1);
      end else begin
        chk("latency", 64'(edges), 64'(lat));
        chk("busy_in_done", 64'(busy_o), 64'd0);
        chk("res_hilo", {res_hi_o, res_lo_o}, {eh, el});
        @(posedge clk);
        @(negedge clk);
        chk("arch_hilo", {hi_o, lo_o}, {eh, el});
      end
    end
  endtask

  initial begin
    logic [63:0] exp;
    logic [3:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    int          pulses;

    n_vec   = 0;
    n_err   = 0;
    rst     = 1'b0;
    start_i = 1'b0;
    op_i    = 4'd0;
    a_i     = '0;
    b_i     = '0;
    annul_i = 1'b0;
    m_hi    = '0;
    m_lo    = '0;

    tbl[0]  = '{4'd1,  32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA};
    tbl[1]  = '{4'd3,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
    tbl[2]  = '{4'd4,  32'hFFFF_FFF9, 32'd2,         32'd1,         32'h7FFF_FFFC};
    tbl[3]  = '{4'd4,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF};
    tbl[4]  = '{4'd3,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000};
    tbl[5]  = '{4'd5,  32'd1,         32'd0,         32'd1,         32'h8000_0000};
    tbl[6]  = '{4'd6,  32'hFFFF_FFFF, 32'd0,         32'd1,         32'hFFFF_FFFF};
    tbl[7]  = '{4'd8,  32'd1,         32'd1,         32'd2,         32'd0};
    tbl[8]  = '{4'd9,  32'd1,         32'd1,         32'd1,         32'hFFFF_FFFF};
    tbl[9]  = '{4'd2,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1};
    tbl[10] = '{4'd3,  32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
    tbl[11] = '{4'd15, 32'd9,         32'd9,         32'd1,         32'hFFFF_FFFD};
    tbl[12] = '{4'd7,  32'hFFFF_FFFF, 32'd3,         32'd1,         32'hFFFF_FFFA};
    tbl[13] = '{4'd10, 32'd2,         32'd3,         32'd1,         32'hFFFF_FFF4};

    // Reset state
    #3;
    chk("rst_busy",   64'(busy_o),   64'd0);
    chk("rst_stall",  64'(stall_o),  64'd0);
    chk("rst_done",   64'(done_o),   64'd0);
    chk("rst_res_hi", 64'(res_hi_o), 64'd0);
    chk("rst_res_lo", 64'(res_lo_o), 64'd0);
    chk("rst_hi",     64'(hi_o),     64'd0);
    chk("rst_lo",     64'(lo_o),     64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Directed vector table
    for (int i = 0; i < 14; i++) begin
      do_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].hi, tbl[i].lo);
      m_hi = tbl[i].hi;
      m_lo = tbl[i].lo;
    end

    // Start together with annul in IDLE is ignored
    start_i = 1'b1;
    annul_i = 1'b1;
    op_i    = 4'd5;
    a_i     = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    annul_i = 1'b0;
    op_i    = 4'd0;
    @(negedge clk);
    chk("annul_start_busy", 64'(busy_o), 64'd0);
    chk("annul_start_hilo", {hi_o, lo_o}, {m_hi, m_lo});

    // Annul during the DONE cycle: done suppressed, HI/LO untouched
    start_i = 1'b1;
    op_i    = 4'd1;
    a_i     = 32'd3;
    b_i     = 32'd5;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    op_i    = 4'd0;
    repeat (c_MUL_LAT) @(posedge clk);
    @(negedge clk);
    annul_i = 1'b1;
    #1;
    chk("annul_done_pulse", 64'(done_o), 64'd0);
    @(posedge clk);
    #1;
    annul_i = 1'b0;
    @(negedge clk);
    chk("annul_done_hilo", {hi_o, lo_o}, {m_hi, m_lo});

    // Annul a divide around iteration 10, then a DIVU right after
    start_i = 1'b1;
    op_i    = 4'd3;
    a_i     = 32'd100;
    b_i     = 32'd7;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    op_i    = 4'd0;
    repeat (11) @(posedge clk);
    @(negedge clk);
    annul_i = 1'b1;
    #1;
    chk("annul_div_busy_before", 64'(busy_o), 64'd1);
    @(posedge clk);
    #1;
    annul_i = 1'b0;
    @(negedge clk);
    chk("annul_div_busy_after", 64'(busy_o), 64'd0);
    chk("annul_div_done", 64'(done_o), 64'd0);
    chk("annul_div_hilo", {hi_o, lo_o}, {m_hi, m_lo});
    exp = ref_model(4'd4, 32'd100, 32'd7, {m_hi, m_lo});
    do_op(4'd4, 32'd100, 32'd7, exp[63:32], exp[31:0]);
    {m_hi, m_lo} = exp;

    // Randomized ops against the reference model
    for (int i = 0; i < 40; i++) begin
      rop = 4'($urandom_range(1, 10));
      ra  = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       begin rb = 32'hFFFF_FFFF; ra = 32'h8000_0000; end
        2:       rb = 32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      exp = ref_model(rop, ra, rb, {m_hi, m_lo});
      do_op(rop, ra, rb, exp[63:32], exp[31:0]);
      {m_hi, m_lo} = exp;
    end

    // start_i held with DIV while busy: stall throughout, one done
    start_i = 1'b1;
    op_i    = 4'd3;
    a_i     = 32'd1000;
    b_i     = 32'hFFFF_FFFD;
    @(posedge clk);
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      chk("held_start_stall", 64'(stall_o), 64'd1);
      if (done_o) pulses++;
    end
    start_i = 1'b0;
    op_i    = 4'd0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done_o) pulses++;
    end
    chk("held_start_done_count", 64'(pulses), 64'd1);
    exp = ref_model(4'd3, 32'd1000, 32'hFFFF_FFFD, {m_hi, m_lo});
    chk("held_start_hilo", {hi_o, lo_o}, exp);
    {m_hi, m_lo} = exp;

    // Reset asserted mid-divide clears everything at once
    start_i = 1'b1;
    op_i    = 4'd4;
    a_i     = 32'd12345;
    b_i     = 32'd17;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    op_i    = 4'd0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_busy",  64'(busy_o),  64'd0);
    chk("midrst_stall", 64'(stall_o), 64'd0);
    chk("midrst_done",  64'(done_o),  64'd0);
    chk("midrst_res",   {res_hi_o, res_lo_o}, 64'd0);
    chk("midrst_hilo",  {hi_o, lo_o}, 64'd0);
    @(negedge clk);
    rst  = 1'b1;
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    exp = ref_model(4'd7, 32'd6, 32'd7, {m_hi, m_lo});
    do_op(4'd7, 32'd6, 32'd7, exp[63:32], exp[31:0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised multi-cycle multiply/divide unit that owns the HI/LO register pair for the execute stage.
- Performs signed and unsigned multiply, multiply-accumulate and multiply-subtract (MADD/MSUB) against HI/LO, and iterative radix-2 divide.
- Also handles MTHI/MTLO writes, and exposes HI/LO for MFHI/MFLO.
- Raises a stall to the pipeline while busy; supports flush (annul) of an in-flight operation.

Parameters:
- WIDTH, 32, operand width; HI and LO are WIDTH bits each.
- MUL_LAT, 2, multiply latency in cycles (>=1), start edge to done.
- DIV_ZERO_Q, all-ones, quotient returned on divide by zero.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start_i  in  1  accept op_i/a_i/b_i this cycle.
- op_i  in  4  0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD, 8 MADDU, 9 MSUB, 10 MSUBU; others = NOP.
- a_i  in  WIDTH  operand rs.
- b_i  in  WIDTH  operand rt.
- annul_i  in  1  flush: abort in-flight op, no HI/LO write.
- busy_o  out  1  long op in flight.
- stall_o  out  1  pipeline hold request.
- done_o  out  1  one-cycle pulse, result valid.
- res_hi_o  out  WIDTH  result high half (remainder for divide), valid with done_o.
- res_lo_o  out  WIDTH  result low half (quotient for divide), valid with done_o.
- hi_o  out  WIDTH  architectural HI register.
- lo_o  out  WIDTH  architectural LO register.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; HI, LO, res_* = 0; busy_o, done_o, stall_o = 0; counters = 0.
- FSM states: IDLE, MUL, DIV_PREP, DIV_ITER, DIV_FIX, DONE.
- Accepting an op (IDLE, start_i=1, annul_i=0):
  - MTHI/MTLO write HI/LO at that same edge. No busy, no done.
  - Mult ops -> MUL, counter = MUL_LAT-1.
  - Div ops -> DIV_PREP.
- start_i while busy_o=1: ignored; upstream holds via stall_o.
- stall_o = busy_o OR (start_i AND op is mult/div/madd/msub AND state IDLE), combinational.
- Multiply:
  - Product is 2*WIDTH bits: signed for MULT/MADD/MSUB, unsigned for the U variants.
  - MADD*: {HI,LO} + product. MSUB*: {HI,LO} - product, modulo 2^(2*WIDTH). HI/LO are sampled at the accept edge.
  - done_o is high in the cycle MUL_LAT edges after the accept edge.
- Divide:
  - DIV_PREP takes absolute values (signed ops) in 1 cycle.
  - DIV_ITER performs WIDTH restoring shift-subtract cycles.
  - DIV_FIX applies signs in 1 cycle: quotient negative iff signs differ; remainder takes the dividend's sign.
  - done_o is high WIDTH+2 edges after the accept edge.
- Divide by zero: quotient = DIV_ZERO_Q, remainder = a_i, same latency.
- Signed overflow (most-negative / -1): quotient = most-negative, remainder = 0.
- DONE state lasts 1 cycle:
  - done_o=1, res_* valid.
  - HI<=res_hi_o and LO<=res_lo_o at the edge ending DONE; returns to IDLE.
  - busy_o drops in the DONE cycle.
  - A start_i presented in the DONE cycle is not accepted; it is accepted next cycle.
- Annul:
  - annul_i=1 in any non-IDLE state, including DONE: return to IDLE at the next edge; HI/LO unchanged; done_o forced 0.
  - annul_i together with start_i in IDLE: start ignored.
- MFHI/MFLO reads hi_o/lo_o directly; the new value is visible from the cycle after the write edge.
- Reset asserted mid-operation: everything cleared immediately; no partial HI/LO write.

Test Plan:
- MULT a=0xFFFFFFFE (-2), b=3, MUL_LAT=2 -> done_o 2 cycles after accept, res_hi=0xFFFFFFFF, res_lo=0xFFFFFFFA; hi_o/lo_o equal these the following cycle.
- DIV a=-7 (0xFFFFFFF9), b=2 -> done_o after 34 cycles, LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); DIVU same operands -> LO=0x7FFFFFFC, HI=1.
- DIVU a=5, b=0 -> LO=0xFFFFFFFF, HI=5. DIV a=0x80000000, b=0xFFFFFFFF -> LO=0x80000000, HI=0.
- MTHI 0x00000001, MTLO 0xFFFFFFFF, then MADDU a=1, b=1 -> HI=2, LO=0; then MSUB a=1, b=1 -> HI=1, LO=0xFFFFFFFF.
- DIV started, annul_i pulsed at iteration 10 -> busy_o=0 next cycle, no done_o, HI/LO keep prior values; new DIVU accepted the cycle after.
- start_i held with DIV while busy -> stall_o=1 throughout, exactly one done_o; rst=0 asserted mid-divide -> all outputs 0 asynchronously.
